// File: rtl/avg_filter_ctrl.sv
// Moving-average controller: pre-scales each sample, drives an external FIFO and accumulator,
// emits the running window sum. Define AVG_PRIME_MUTE_EN to zero outputs until the window is full.
module avg_filter_ctrl #(
  parameter int DEPTH_LOG2 = 3,
  parameter int WIDTH      = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             flush,
  output logic             fifo_wr,
  output logic             fifo_rd,
  output logic             fifo_clr,
  output logic [WIDTH-1:0] fifo_wdata,
  input  logic [WIDTH-1:0] fifo_rdata,
  output logic             acc_en,
  output logic             acc_clr,
  output logic [WIDTH-1:0] acc_r_data,
  output logic [WIDTH-1:0] acc_w_data,
  input  logic [WIDTH-1:0] acc_q,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  localparam int N  = 1 << DEPTH_LOG2;
  localparam int CW = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {IDLE, STEP, EMIT} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] scaled;
  logic             stepWr;
  logic             stepRd;
  logic             clrPulse;
  logic             outValidQ;
  logic             startup;
  logic             windowFull;

  assign windowFull = (cnt == CW'(N));

  // Strobes are registered at the accept edge so they are high during the STEP cycle;
  // startup forces one clear pulse in the first cycle after reset releases.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      scaled    <= '0;
      stepWr    <= 1'b0;
      stepRd    <= 1'b0;
      clrPulse  <= 1'b0;
      outValidQ <= 1'b0;
      startup   <= 1'b1;
    end else begin
      startup  <= 1'b0;
      clrPulse <= 1'b0;
      stepWr   <= 1'b0;
      stepRd   <= 1'b0;
      case (state)
        IDLE: begin
          if (flush) begin
            clrPulse <= 1'b1;
            cnt      <= '0;
          end else if (in_valid && !startup) begin
            scaled <= WIDTH'($signed(in_data) >>> DEPTH_LOG2);
            stepWr <= 1'b1;
            stepRd <= windowFull;
            state  <= STEP;
          end
        end
        STEP: begin
          if (!windowFull) cnt <= cnt + 1'b1;
          outValidQ <= 1'b1;
          state     <= EMIT;
        end
        EMIT: begin
          if (out_ready) begin
            outValidQ <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Everything is gated by reset so a transaction caught mid-flight strobes nothing that cycle.
  assign in_ready   = (state == IDLE) && !flush && !startup && !reset;
  assign fifo_wr    = stepWr & ~reset;
  assign acc_en     = stepWr & ~reset;
  assign fifo_rd    = stepRd & ~reset;
  assign fifo_clr   = (clrPulse | startup) & ~reset;
  assign acc_clr    = (clrPulse | startup) & ~reset;
  assign fifo_wdata = scaled;
  assign acc_w_data = scaled;
  assign acc_r_data = fifo_rd ? fifo_rdata : '0;
  assign out_valid  = outValidQ & ~reset;

`ifdef AVG_PRIME_MUTE_EN
  assign out_data = (out_valid && windowFull) ? acc_q : '0;
`else
  assign out_data = out_valid ? acc_q : '0;
`endif

endmodule

// File: tb/tb_avg_filter_ctrl.sv
// Directed bench for avg_filter_ctrl with behavioural FIFO and accumulator models;
// expectations follow AVG_PRIME_MUTE_EN when it is defined.
module tb_avg_filter_ctrl;

  localparam int WIDTH = 24;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             flush;
  logic             fifo_wr, fifo_rd, fifo_clr;
  logic [WIDTH-1:0] fifo_wdata;
  logic [WIDTH-1:0] fifo_rdata;
  logic             acc_en, acc_clr;
  logic [WIDTH-1:0] acc_r_data, acc_w_data;
  logic [WIDTH-1:0] acc_q;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] fifoQ[$];

  avg_filter_ctrl #(.DEPTH_LOG2(3), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .flush(flush),
    .fifo_wr(fifo_wr), .fifo_rd(fifo_rd), .fifo_clr(fifo_clr),
    .fifo_wdata(fifo_wdata), .fifo_rdata(fifo_rdata),
    .acc_en(acc_en), .acc_clr(acc_clr), .acc_r_data(acc_r_data),
    .acc_w_data(acc_w_data), .acc_q(acc_q),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // External accumulator: subtract the retiring sample, add the new one
  initial acc_q = '0;
  always @(posedge clk) begin
    if (acc_clr) acc_q <= '0;
    else if (acc_en) acc_q <= acc_q - acc_r_data + acc_w_data;
  end

  // Show-ahead FIFO: head of the queue is always visible on fifo_rdata
  initial fifo_rdata = '0;
  always @(posedge clk) begin
    if (fifo_clr) fifoQ.delete();
    else begin
      if (fifo_rd && fifoQ.size() > 0) void'(fifoQ.pop_front());
      if (fifo_wr) fifoQ.push_back(fifo_wdata);
    end
    fifo_rdata <= (fifoQ.size() > 0) ? fifoQ[0] : '0;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One full sample: accept, STEP strobes, EMIT value, handshake back to IDLE
  task automatic applyStimulus(input string tag, input logic [WIDTH-1:0] data,
                               input logic [WIDTH-1:0] expW, input logic expRd,
                               input logic [WIDTH-1:0] expOut);
    for (int i = 0; i < 10 && !in_ready; i++) tick();
    checkOutput({tag, "_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = data;
    tick();
    in_valid = 1'b0;
    checkOutput({tag, "_wr"},    32'(fifo_wr & acc_en), 32'd1);
    checkOutput({tag, "_rd"},    32'(fifo_rd), 32'(expRd));
    checkOutput({tag, "_wdata"}, 32'(fifo_wdata), 32'(expW));
    checkOutput({tag, "_lat"},   32'(out_valid), 32'd0);
    tick();
    checkOutput({tag, "_ovld"},  32'(out_valid), 32'd1);
    checkOutput({tag, "_strb"},  32'(fifo_wr | acc_en | fifo_rd), 32'd0);
    checkOutput({tag, "_out"},   32'(out_data), 32'(expOut));
    tick();
    checkOutput({tag, "_done"},  32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [WIDTH-1:0] expOut;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    checkOutput("rst_ovld",  32'(out_valid), 32'd0);
    checkOutput("rst_clr",   32'(fifo_clr | acc_clr), 32'd0);
    checkOutput("rst_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_wdata", 32'(fifo_wdata), 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("post_rst_clr",   32'(fifo_clr & acc_clr), 32'd1);
    checkOutput("post_rst_ready", 32'(in_ready), 32'd0);
    tick();
    checkOutput("post_rst_clr_end", 32'(fifo_clr | acc_clr), 32'd0);

    // Priming: 8 x 0x000800, outputs ramp 0x100..0x800
    for (int i = 0; i < 8; i++) begin
`ifdef AVG_PRIME_MUTE_EN
      expOut = (i == 7) ? 24'h000800 : 24'h000000;
`else
      expOut = 24'(32'h100 * (i + 1));
`endif
      applyStimulus($sformatf("prime%0d", i), 24'h000800, 24'h000100, 1'b0, expOut);
    end

    applyStimulus("steady",   24'h001000, 24'h000200, 1'b1, 24'h000900);
    applyStimulus("negative", 24'hFFF800, 24'hFFFF00, 1'b1, 24'h000700);

    // Backpressure: hold EMIT for 5 cycles with a new sample already waiting
    in_valid = 1'b1; in_data = 24'h000800;
    tick();
    checkOutput("bp_rd", 32'(fifo_rd), 32'd1);
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("bp_vld%0d", i),   32'(out_valid), 32'd1);
      checkOutput($sformatf("bp_data%0d", i),  32'(out_data), 32'h000700);
      checkOutput($sformatf("bp_ready%0d", i), 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    checkOutput("bp_idle_vld",   32'(out_valid), 32'd0);
    checkOutput("bp_idle_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    checkOutput("bp_resume_wr", 32'(fifo_wr), 32'd1);
    tick();
    checkOutput("bp_resume_out", 32'(out_data), 32'h000700);
    tick();

    // Flush with in_valid at the same time: flush wins, window restarts
    flush = 1'b1; in_valid = 1'b1; in_data = 24'h000800;
    #1;
    checkOutput("fl_ready", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checkOutput("fl_clr",  32'(fifo_clr & acc_clr), 32'd1);
    checkOutput("fl_noacc", 32'(fifo_wr), 32'd0);
    tick();
    checkOutput("fl_clr_end", 32'(fifo_clr | acc_clr), 32'd0);
`ifdef AVG_PRIME_MUTE_EN
    applyStimulus("fl_prime", 24'h000800, 24'h000100, 1'b0, 24'h000000);
`else
    applyStimulus("fl_prime", 24'h000800, 24'h000100, 1'b0, 24'h000100);
`endif

    // Reset while in STEP: no strobes in the reset cycle, clear pulse afterwards
    in_valid = 1'b1; in_data = 24'h000800;
    tick();
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    checkOutput("rst_step_wr",    32'(fifo_wr | acc_en), 32'd0);
    checkOutput("rst_step_ready", 32'(in_ready), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    checkOutput("rst_step_clr",  32'(fifo_clr & acc_clr), 32'd1);
    checkOutput("rst_step_ovld", 32'(out_valid), 32'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/avg_filter_ctrl.md
AVG_FILTER_CTRL -- requirements
Module: avg_filter_ctrl

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 3, meaning the window is N = 2^DEPTH_LOG2 samples.
REQ-002 SHALL have parameter WIDTH, default 24, meaning the sample width in bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have ports in_valid (input, 1), in_data (input, WIDTH) and in_ready (output, 1): the raw sample handshake.
REQ-006 SHALL have port flush, input, 1 bit: clears the window history.
REQ-007 SHALL have FIFO ports fifo_wr (output, 1), fifo_rd (output, 1), fifo_clr (output, 1), fifo_wdata (output, WIDTH) and fifo_rdata (input, WIDTH, show-ahead).
REQ-008 SHALL have accumulator ports acc_en (output, 1), acc_clr (output, 1), acc_r_data (output, WIDTH), acc_w_data (output, WIDTH) and acc_q (input, WIDTH).
REQ-009 SHALL have ports out_valid (output, 1), out_data (output, WIDTH) and out_ready (input, 1): the filtered sample handshake.

Function
REQ-010 SHALL implement FSM states IDLE, STEP and EMIT, and SHALL hold a fill counter cnt with range 0..N.
REQ-011 SHALL assert in_ready only in IDLE with flush low; a sample is accepted when in_valid and in_ready are both high, and the FSM SHALL then move to STEP.
REQ-012 SHALL, on accept, register scaled = in_data arithmetically shifted right by DEPTH_LOG2 (sign-extended); fifo_wdata and acc_w_data SHALL equal scaled.
REQ-013 SHALL, in STEP, assert fifo_wr and acc_en for exactly one cycle and then move to EMIT.
REQ-014 SHALL, in STEP with cnt == N, assert fifo_rd and drive acc_r_data = fifo_rdata, leaving cnt unchanged.
REQ-015 SHALL, in STEP with cnt < N, keep fifo_rd low, drive acc_r_data = 0 and increment cnt.
REQ-016 SHALL, in EMIT, assert out_valid with out_data = acc_q and hold both stable until out_ready; out_valid and out_ready both high SHALL return the FSM to IDLE.
REQ-017 SHALL give a latency from the accept edge to out_valid high of 2 cycles; a back-to-back throughput of 1 sample per 3 cycles is acceptable.
REQ-018 SHALL, when flush is high in IDLE, pulse fifo_clr and acc_clr for one cycle and set cnt to 0; a flush in STEP or EMIT SHALL be ignored (the level must be held until IDLE).
REQ-019 SHALL, when flush and in_valid are both high in IDLE, give flush priority, with no accept that cycle.
REQ-020 SHALL drive fifo_wr, fifo_rd, acc_en, fifo_clr and acc_clr low outside the conditions above.
REQ-021 SHALL keep all arithmetic at WIDTH bits, two's complement, wrapping; overflow is prevented by the pre-scaling.

Reset
REQ-022 SHALL, on reset, force state IDLE, cnt 0 and the registered sample 0, and drive out_valid, out_data, fifo_wr, fifo_rd, fifo_clr, acc_en and acc_clr to 0.
REQ-023 SHALL, on reset mid-STEP or mid-EMIT, abandon the transaction with no strobe that cycle, and deassert in_ready during the reset cycle.
REQ-024 SHALL pulse fifo_clr and acc_clr in the first cycle after reset deasserts.

Configuration
REQ-025 SHALL, with AVG_PRIME_MUTE_EN defined, drive out_data = 0 in EMIT while cnt < N; the handshake is unchanged.
REQ-026 SHALL, without AVG_PRIME_MUTE_EN, drive out_data = acc_q in EMIT, so partial window sums are output during priming.

Verification
REQ-027 SHALL cover priming: 8 samples of 0x000800 with a model accumulator -> outputs 0x000100, 0x000200, ... 0x000800; fifo_rd low on all 8.
REQ-028 SHALL cover steady state: 9th sample 0x001000 with fifo_rdata 0x000100 -> fifo_rd high in STEP and output 0x000800 - 0x000100 + 0x000200 = 0x000900.
REQ-029 SHALL cover a negative input: in_data 0xFFF800 (-2048) -> fifo_wdata 0xFFFF00 (-256).
REQ-030 SHALL cover backpressure: out_ready low for 5 cycles in EMIT -> out_valid and out_data stable and in_ready low throughout; accept resumes 1 cycle after the handshake.
REQ-031 SHALL cover flush: flush and in_valid high together in IDLE with cnt = 8 -> fifo_clr and acc_clr one-cycle pulse, cnt = 0, no accept; the next sample takes the priming path.
REQ-032 SHALL cover mute: AVG_PRIME_MUTE_EN defined with 3 samples of 0x000800 -> out_data 0, 0, 0; the 8th output is 0x000800.
